dmem_bridge: RTL
================

Name: dmem_bridge

Overview:
- Sits directly downstream of the hart's data-memory port.
- Converts the hart's single-cycle style dmem request (combinational read, next-edge write) into a valid/ready request plus rvalid response transaction on a multi-cycle data memory.
- Asserts a stall back to the hart until the access completes, then presents read data for exactly one cycle so the hart can retire the load or store.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before the watchdog aborts (used only with DMEM_BRIDGE_TIMEOUT_EN); counter width = $clog2(TIMEOUT_CYCLES+1).

Ports:
- i_clk  in  1  global clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_req_addr  in  32  hart dmem address, word aligned (bits [1:0] ignored).
- i_req_ren  in  1  hart load request.
- i_req_wen  in  1  hart store request.
- i_req_wdata  in  32  store data, already lane-shifted.
- i_req_mask  in  4  byte-lane mask.
- o_stall  out  1  hart must hold PC and request stable while high.
- o_rsp_valid  out  1  access complete this cycle.
- o_rsp_rdata  out  32  load data; lanes not in mask forced to 0.
- o_rsp_err  out  1  access aborted (illegal request or timeout); valid with o_rsp_valid.
- o_mem_valid  out  1  request valid to memory.
- i_mem_ready  in  1  memory accepts request when valid&&ready.
- o_mem_addr  out  32  registered {addr[31:2],2'b00}.
- o_mem_wen  out  1  1=write, 0=read.
- o_mem_wdata  out  32  registered write data.
- o_mem_mask  out  4  registered mask.
- i_mem_rvalid  in  1  read response valid.
- i_mem_rdata  in  32  read response data.

Behaviour:
- Clock and reset: one clock, i_clk; reset is synchronous, active-low, on i_rst_n.
- Reset values: state=IDLE; all outputs 0; rdata/err registers 0.
- Reset asserted mid-transaction:
  - Returns to IDLE next edge and drops o_mem_valid.
  - A late i_mem_rvalid for the aborted read is ignored.
- States: IDLE, REQ, WAIT, DONE.
- o_stall = (i_req_ren | i_req_wen) & (state != DONE), combinational.
- IDLE:
  - Idle while no request.
  - On ren^wen with mask != 0: capture addr/wdata/mask/wen into output registers, go to REQ.
  - On ren&wen, or mask==0 with ren|wen: no memory access; set err=1, go to DONE.
- REQ:
  - o_mem_valid=1, holding all o_mem_* stable until accept.
  - On valid&&ready: a write goes to DONE (write complete on accept); a read goes to WAIT.
- WAIT:
  - o_mem_valid=0.
  - On i_mem_rvalid: capture i_mem_rdata with unmasked lanes zeroed, go to DONE.
  - i_mem_rvalid is sampled only in WAIT; it is ignored in every other state.
- DONE:
  - o_rsp_valid=1 and o_stall=0 for exactly one cycle; o_rsp_rdata/o_rsp_err reflect captured values.
  - Unconditionally returns to IDLE.
  - err clears on leaving DONE; rdata holds until the next read capture.
- Latency with zero-wait memory (ready=1, rvalid in first WAIT cycle):
  - Read: 4 cycles, request seen to o_rsp_valid at cycle 3.
  - Write: 3 cycles.
  - Illegal request: 2 cycles.
- Back-to-back accesses: the next request is first seen in the cycle after DONE (IDLE). No pipelining; one outstanding transaction max.
- Request inputs change while in REQ/WAIT: ignored, since registered copies drive memory.

Optional Feature:
- Macro: DMEM_BRIDGE_TIMEOUT_EN.
- Defined:
  - Counter resets on entering REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: drop o_mem_valid, go to DONE with err=1, rdata=0.
  - A subsequent stale rvalid is ignored.
- Not defined: no counter is present; the bridge waits indefinitely in REQ/WAIT.

Test Plan:
- Read, ready=1, rvalid the cycle after accept: addr=0x1004, mask=4'b1100, mem rdata=0xAABBCCDD -> o_mem_addr=0x1004, o_stall high 3 cycles, o_rsp_valid at cycle 3, o_rsp_rdata=0xAABB0000, err=0.
- Write with ready held low 5 cycles: addr=0x2003, wdata=0x7F000000, mask=4'b1000 -> o_mem_valid high 6 cycles with stable addr 0x2000/mask 4'b1000/wen=1, DONE the cycle after accept, no rvalid needed.
- Illegal request: ren=wen=1 -> o_mem_valid never asserted, o_rsp_valid+o_rsp_err at cycle 1, back to IDLE at cycle 2.
- Reset mid-WAIT: i_rst_n=0 for one cycle, then an rvalid pulse -> state IDLE, o_rsp_valid stays 0, all outputs 0.
- Back-to-back load then store with ready=1 -> second o_mem_valid rises exactly 2 cycles after first o_rsp_valid; stray rvalid in IDLE has no effect.
- DMEM_BRIDGE_TIMEOUT_EN with TIMEOUT_CYCLES=8, rvalid never asserted -> o_rsp_valid with err=1 and rdata=0 after 8 cycles in REQ+WAIT.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge
//   Converts the hart's single-cycle dmem request into a valid/ready request
//   plus rvalid response on a multi-cycle data memory. The hart is stalled
//   until the access finishes. Read data and error are then presented for
//   exactly one cycle, in DONE.
//
//   Ports
//     i_clk, i_rst_n            clock and synchronous active-low reset
//     i_req_addr/ren/wen/...    hart dmem request (held stable while stalled)
//     o_stall                   hart hold request
//     o_rsp_valid/rdata/err     one-cycle completion pulse with result
//     o_mem_valid/addr/wen/...  registered request to memory (valid/ready)
//     i_mem_ready               memory accepts when valid && ready
//     i_mem_rvalid/rdata        read response from memory
//
//   Optional feature
//     DMEM_BRIDGE_TIMEOUT_EN    adds a watchdog on REQ+WAIT. After
//                               TIMEOUT_CYCLES cycles the access is aborted
//                               with err=1 and rdata=0.
module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_stall,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic        req_any, req_legal, req_illegal;
    logic        mem_fire;
    logic        timeout_hit;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] lane_mask;

    assign req_any     = i_req_ren | i_req_wen;
    assign req_legal   = (i_req_ren ^ i_req_wen) && (i_req_mask != 4'b0000);
    assign req_illegal = req_any && !req_legal;
    assign mem_fire    = (state == REQ) && i_mem_ready;

    // Lane mask comes from the registered request mask, not the live hart inputs.
    assign lane_mask = {{8{o_mem_mask[3]}}, {8{o_mem_mask[2]}},
                        {8{o_mem_mask[1]}}, {8{o_mem_mask[0]}}};

    // The address is issued word aligned, so the byte offset is dropped.
    wire unused_addr_lsb = ^i_req_addr[1:0];

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    // The counter holds 0..TIMEOUT_CYCLES-1 across REQ+WAIT. The watchdog
    // fires on the last of those cycles, so REQ+WAIT never exceeds
    // TIMEOUT_CYCLES cycles.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] to_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            to_cnt <= '0;
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else if ((state == REQ) || (state == WAIT)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = ((state == REQ) || (state == WAIT)) && (to_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
    wire unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic. A real handshake (accept or rvalid) wins over a
    // watchdog expiry in the same cycle, because the memory has acted on it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_legal)        state_nxt = REQ;
                else if (req_illegal) state_nxt = DONE;
            end
            REQ: begin
                if (mem_fire)         state_nxt = o_mem_wen ? DONE : WAIT;
                else if (timeout_hit) state_nxt = DONE;
            end
            WAIT: begin
                if (i_mem_rvalid)     state_nxt = DONE;
                else if (timeout_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_mem_valid = (state == REQ);
        o_rsp_valid = (state == DONE);
        o_stall     = req_any && (state != DONE);
    end

    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

    // Request capture and response registers. rvalid is only honoured in
    // WAIT, so stale responses after a reset or abort fall on the floor.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_mem_addr  <= '0;
            o_mem_wen   <= 1'b0;
            o_mem_wdata <= '0;
            o_mem_mask  <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_legal) begin
                        o_mem_addr  <= {i_req_addr[31:2], 2'b00};
                        o_mem_wen   <= i_req_wen;
                        o_mem_wdata <= i_req_wdata;
                        o_mem_mask  <= i_req_mask;
                    end else if (req_illegal) begin
                        err_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (!mem_fire && timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                WAIT: begin
                    if (i_mem_rvalid) begin
                        rdata_q <= i_mem_rdata & lane_mask;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                DONE:    err_q <= 1'b0;
                default: err_q <= 1'b0;
            endcase
        end
    end

endmodule
